// File: rtl/arm_pose_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arm_pose_sequencer
// Description : Pose table plus playback engine that feeds (servo, pwm, time)
//               commands to the servo UART formatter over valid/ready, then
//               holds for each pose's move time. Single-shot or looped play,
//               with a graceful stop.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_pose_sequencer #(
  parameter int NUM_SERVOS   = 6,
  parameter int NUM_POSES    = 8,
  parameter int TICKS_PER_MS = 50000,
  parameter int PWM_MIN      = 500,
  parameter int PWM_MAX      = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_pose,
  input  logic [2:0]  wr_servo,
  input  logic [11:0] wr_pwm,
  input  logic [1:0]  wr_time,
  input  logic [2:0]  last_pose,
  input  logic        loop_en,
  input  logic        start,
  input  logic        stop,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  servo_id,
  output logic [11:0] pwm_value,
  output logic [1:0]  time_value,
  output logic        busy,
  output logic [2:0]  pose_idx,
  output logic        done
);

  localparam logic [3:0]  c_NUM_SERVOS = 4'(NUM_SERVOS);
  localparam logic [3:0]  c_NUM_POSES  = 4'(NUM_POSES);
  localparam logic [2:0]  c_LAST_SERVO = 3'(NUM_SERVOS - 1);
  localparam logic [2:0]  c_MAX_POSE   = 3'(NUM_POSES - 1);
  localparam logic [11:0] c_PWM_MIN    = 12'(PWM_MIN);
  localparam logic [11:0] c_PWM_MAX    = 12'(PWM_MAX);
  localparam logic [11:0] c_PWM_RST    = 12'd1500;
  localparam logic [1:0]  c_TIME_RST   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  pose_q, pose_d;
  logic [2:0]  servo_q, servo_d;
  logic [2:0]  last_q, last_d;
  logic [31:0] hold_q, hold_d;
  logic        stop_pend_q, stop_pend_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [2:0]  id_q;
  logic [11:0] pwm_q;
  logic [1:0]  time_q;

  logic [11:0] pwm_tab_q [NUM_POSES][NUM_SERVOS];
  logic [1:0]  time_tab_q [NUM_POSES];

  logic        w_load;
  logic        w_wr_ok;
  logic [11:0] w_wr_pwm;
  logic [2:0]  w_last_clamped;
  logic [11:0] w_rd_pwm;
  logic [1:0]  w_rd_time;

  // Move-time code to hold length in clock cycles.
  function automatic logic [31:0] hold_cycles(input logic [1:0] code);
    logic [31:0] r;
    case (code)
      2'd0:    r = 32'(250 * TICKS_PER_MS);
      2'd1:    r = 32'(500 * TICKS_PER_MS);
      2'd2:    r = 32'(1000 * TICKS_PER_MS);
      default: r = 32'(2000 * TICKS_PER_MS);
    endcase
    return r;
  endfunction

  assign w_wr_ok        = wr_en && ({1'b0, wr_pose} < c_NUM_POSES) &&
                          ({1'b0, wr_servo} < c_NUM_SERVOS);
  assign w_wr_pwm       = (wr_pwm < c_PWM_MIN) ? c_PWM_MIN :
                          (wr_pwm > c_PWM_MAX) ? c_PWM_MAX : wr_pwm;
  assign w_last_clamped = ({1'b0, last_pose} >= c_NUM_POSES) ? c_MAX_POSE : last_pose;

  // The command register samples the entry addressed by the next pose/servo.
  assign w_rd_pwm  = pwm_tab_q[pose_d][servo_d];
  assign w_rd_time = time_tab_q[pose_d];

  // Pose table storage; writes land after the edge, so a same-cycle read sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_POSES; p++) begin
        time_tab_q[p] <= c_TIME_RST;
        for (int s = 0; s < NUM_SERVOS; s++) begin
          pwm_tab_q[p][s] <= c_PWM_RST;
        end
      end
    end else if (w_wr_ok) begin
      pwm_tab_q[wr_pose][wr_servo] <= w_wr_pwm;
      time_tab_q[wr_pose]          <= wr_time;
    end
  end

  // Playback next-state logic: issue one command per servo, then hold, then advance/wrap/finish.
  always_comb begin
    state_d     = state_q;
    pose_d      = pose_q;
    servo_d     = servo_q;
    last_d      = last_q;
    hold_d      = hold_q;
    stop_pend_d = stop_pend_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    w_load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d      = w_last_clamped;
          pose_d      = 3'd0;
          servo_d     = 3'd0;
          stop_pend_d = 1'b0;
          w_load      = 1'b1;
          valid_d     = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (valid_q && cmd_ready) begin
          valid_d = 1'b0;
          if (stop || stop_pend_q) begin
            stop_pend_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else if (servo_q == c_LAST_SERVO) begin
            hold_d  = hold_cycles(time_q) - 32'd1;
            state_d = S_HOLD;
          end else begin
            servo_d = servo_q + 3'd1;
          end
        end else if (valid_q) begin
          if (stop) begin
            stop_pend_d = 1'b1;
          end
        end else if (stop || stop_pend_q) begin
          // Gap cycle between commands: nothing outstanding, stop right away.
          stop_pend_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          w_load  = 1'b1;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (stop) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (hold_q == 32'd0) begin
          if (pose_q < last_q) begin
            pose_d  = pose_q + 3'd1;
            servo_d = 3'd0;
            w_load  = 1'b1;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else if (loop_en) begin
            pose_d  = 3'd0;
            servo_d = 3'd0;
            w_load  = 1'b1;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and the registered command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pose_q      <= 3'd0;
      servo_q     <= 3'd0;
      last_q      <= 3'd0;
      hold_q      <= 32'd0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      id_q        <= 3'd0;
      pwm_q       <= 12'd0;
      time_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      pose_q      <= pose_d;
      servo_q     <= servo_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      stop_pend_q <= stop_pend_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      if (w_load) begin
        id_q   <= servo_d;
        pwm_q  <= w_rd_pwm;
        time_q <= w_rd_time;
      end
    end
  end

  assign cmd_valid  = valid_q;
  assign servo_id   = id_q;
  assign pwm_value  = pwm_q;
  assign time_value = time_q;
  assign busy       = (state_q != S_IDLE);
  assign pose_idx   = pose_q;
  assign done       = done_q;

endmodule
`default_nettype wire
